// File: rtl/sb_pkg.sv
// Shared types for the store buffer: store size codes and the buffered entry layout.
package sb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } sz_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        sz_e         size;
        logic [31:0] pc;
        logic [3:0]  mask;
        logic [31:0] aligned;
    } sb_entry_t;

    // Size code 11 behaves as a word store.
    function automatic sz_e norm_size(input logic [1:0] s);
        case (s)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/sb_lane_gen.sv
// Byte-lane mask and lane-aligned data for a store, from address low bits and size.
module sb_lane_gen
    import sb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [3:0]  mask,
    output logic [31:0] aligned
);

    always_comb begin
        mask    = 4'b1111;
        aligned = data;
        case (norm_size(size))
            SZ_BYTE: begin
                mask    = 4'b0001 << addr_lo;
                aligned = {4{data[7:0]}};
            end
            SZ_HALF: begin
                mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                aligned = {2{data[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between MEM-stage store issue and data memory,
// with byte-merged store-to-load forwarding from all pending entries.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    input  logic [31:0]              st_pc,
    input  logic                     dm_grant,
    output logic                     dm_we,
    output logic                     dm_sw,
    output logic                     dm_sh,
    output logic                     dm_sb,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wd,
    output logic [31:0]              dm_pc,
    input  logic [31:0]              ld_addr,
    input  logic [31:0]              dm_rd,
    output logic [31:0]              ld_data,
    output logic [3:0]               ld_hit,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             push, pop;
    logic [3:0]       new_mask;
    logic [31:0]      new_aligned;
    sb_entry_t        head;
    sb_entry_t        new_ent;

    logic             unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    sb_lane_gen u_lane_gen (
        .addr_lo (st_addr[1:0]),
        .size    (st_size),
        .data    (st_data),
        .mask    (new_mask),
        .aligned (new_aligned)
    );

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;
    assign count    = count_q;

    assign push = st_valid && st_ready;
    assign pop  = !empty && dm_grant;
    assign head = ent_q[rd_ptr_q];

    always_comb begin
        new_ent.addr    = st_addr;
        new_ent.data    = st_data;
        new_ent.size    = norm_size(st_size);
        new_ent.pc      = st_pc;
        new_ent.mask    = new_mask;
        new_ent.aligned = new_aligned;
    end

    // Push and pop can never target the same slot: that needs empty (no pop) or full (no push).
    always_comb begin
        ent_d    = ent_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            ent_d[wr_ptr_q]   = new_ent;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_comb begin
        dm_we   = pop && !reset;
        dm_sw   = dm_we && (head.size == SZ_WORD);
        dm_sh   = dm_we && (head.size == SZ_HALF);
        dm_sb   = dm_we && (head.size == SZ_BYTE);
        dm_addr = head.addr;
        dm_wd   = head.data;
        dm_pc   = head.pc;
    end

    // Walk oldest to youngest so a younger matching entry overwrites an older one per lane.
    logic [31:0]   fwd_data;
    logic [3:0]    fwd_hit;
    logic [PW-1:0] idx;

    always_comb begin
        fwd_data = dm_rd;
        fwd_hit  = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (valid_q[idx] && (ent_q[idx].addr[31:2] == ld_addr[31:2])) begin
                for (int unsigned l = 0; l < 4; l++) begin
                    if (ent_q[idx].mask[l]) begin
                        fwd_data[8*l +: 8] = ent_q[idx].aligned[8*l +: 8];
                        fwd_hit[l]         = 1'b1;
                    end
                end
            end
        end
    end

    assign ld_data = reset ? dm_rd : fwd_data;
    assign ld_hit  = reset ? 4'b0000 : fwd_hit;

endmodule
